mc_control_unit: RTL and testbench

- Multicycle control FSM for the RV32I core. It sits directly upstream of the datapath.
- It decodes `instrCode` and sequences each instruction through FETCH, DECODE, EXE and, for loads/stores, MEM and WB.
- It drives every datapath control strobe, and `busReq`/`busWe` toward data memory.
- Memory accesses use a ready handshake; the FSM holds in MEM until the slave responds.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_control_unit_if.sv | 38 +++
 rtl/mc_alu_decoder.sv | 29 ++
 rtl/mc_control_unit.sv | 145 ++++++++++++++
 tb/tb_mc_control_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared constants and state type for the RV32I multicycle
//                control unit (opcodes, ALU ops, write-back source codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // RV32I major opcodes handled by the control unit
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // ALU operation codes: {instr[30], funct3} style encoding
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Register-file write-data source select
  localparam logic [2:0] WD_ALU   = 3'd0;
  localparam logic [2:0] WD_MEM   = 3'd1;
  localparam logic [2:0] WD_IMM   = 3'd2;
  localparam logic [2:0] WD_PCIMM = 3'd3;
  localparam logic [2:0] WD_PC4   = 3'd4;

  // Control FSM states
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    R_EXE  = 4'd2,
    I_EXE  = 4'd3,
    B_EXE  = 4'd4,
    LU_EXE = 4'd5,
    AU_EXE = 4'd6,
    J_EXE  = 4'd7,
    JL_EXE = 4'd8,
    S_EXE  = 4'd9,
    S_MEM  = 4'd10,
    L_EXE  = 4'd11,
    L_MEM  = 4'd12,
    L_WB   = 4'd13
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_unit_if
//  Description : Instruction/handshake inputs and datapath/bus control strobes
//                exchanged between the control unit and the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_unit_if;
  logic [31:0] instrCode;
  logic        busReady;
  logic        PCEn;
  logic        regFileWe;
  logic        aluSrcMuxSel;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic        busReq;
  logic        busWe;
  logic [2:0]  memFunct3;
  logic        illegalInstr;

  // Control unit side: consumes the instruction and bus ready, drives strobes
  modport master (
    input  instrCode, busReady,
    output PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
           branch, jal, jalr, busReq, busWe, memFunct3, illegalInstr
  );

  // Datapath side: supplies the instruction and bus ready, receives strobes
  modport slave (
    output instrCode, busReady,
    input  PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
           branch, jal, jalr, busReq, busWe, memFunct3, illegalInstr
  );
endinterface
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mc_alu_decoder
//  Description : Maps opcode/funct3/instr[30] to the 4-bit ALU operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
  import mc_pkg::*;
(
  input  wire logic [6:0] opcode,
  input  wire logic [2:0] funct3,
  input  wire logic       instr30,
  output logic      [3:0] alu_op
);

  // instr[30] only selects an op for R-type and for I-type shifts-right;
  // in other I-type forms it is an immediate bit and must be ignored.
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_R:    alu_op = {instr30, funct3};
      OP_I:    alu_op = (funct3 == 3'b101) ? {instr30, funct3} : {1'b0, funct3};
      OP_B:    alu_op = {1'b0, funct3};
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_unit
//  Description : Multicycle RV32I control FSM. Sequences each instruction
//                through FETCH/DECODE/EXE (+MEM/WB for loads and stores) and
//                drives all datapath and data-bus control strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control_unit
  import mc_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  mc_control_unit_if.master bus
);

  state_t      state;
  state_t      next_state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        unused_instr;

  assign opcode       = bus.instrCode[6:0];
  assign funct3       = bus.instrCode[14:12];
  assign unused_instr = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};

  mc_alu_decoder u_alu_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .instr30 (bus.instrCode[30]),
    .alu_op  (alu_op)
  );

  // State register; reset forces FETCH immediately, even mid-access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state: opcode dispatch in DECODE, ready-gated exits from MEM states
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:     next_state = R_EXE;
          OP_I:     next_state = I_EXE;
          OP_L:     next_state = L_EXE;
          OP_S:     next_state = S_EXE;
          OP_B:     next_state = B_EXE;
          OP_LUI:   next_state = LU_EXE;
          OP_AUIPC: next_state = AU_EXE;
          OP_JAL:   next_state = J_EXE;
          OP_JALR:  next_state = JL_EXE;
          default:  next_state = FETCH;
        endcase
      end
      S_EXE:  next_state = S_MEM;
      S_MEM:  next_state = bus.busReady ? FETCH : S_MEM;
      L_EXE:  next_state = L_MEM;
      L_MEM:  next_state = bus.busReady ? L_WB : L_MEM;
      default: next_state = FETCH;
    endcase
  end

  assign bus.memFunct3 = funct3;

  // Output decode; load/store states pin the ALU to imm+ADD so the
  // free-running address register holds steady across the access
  always_comb begin
    bus.PCEn          = 1'b0;
    bus.regFileWe     = 1'b0;
    bus.aluSrcMuxSel  = 1'b0;
    bus.aluControl    = ALU_ADD;
    bus.RFWDSrcMuxSel = WD_ALU;
    bus.branch        = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    bus.busReq        = 1'b0;
    bus.busWe         = 1'b0;
    bus.illegalInstr  = 1'b0;
    case (state)
      FETCH:  bus.PCEn = 1'b1;
      DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_L, OP_S, OP_B,
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: bus.illegalInstr = 1'b0;
          default:                           bus.illegalInstr = 1'b1;
        endcase
      end
      R_EXE: begin
        bus.regFileWe  = 1'b1;
        bus.aluControl = alu_op;
      end
      I_EXE: begin
        bus.regFileWe    = 1'b1;
        bus.aluSrcMuxSel = 1'b1;
        bus.aluControl   = alu_op;
      end
      B_EXE: begin
        bus.branch     = 1'b1;
        bus.aluControl = alu_op;
      end
      LU_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = WD_IMM;
      end
      AU_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = WD_PCIMM;
      end
      J_EXE: begin
        bus.jal           = 1'b1;
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = WD_PC4;
      end
      JL_EXE: begin
        bus.jal           = 1'b1;
        bus.jalr          = 1'b1;
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = WD_PC4;
      end
      S_EXE, L_EXE: bus.aluSrcMuxSel = 1'b1;
      S_MEM: begin
        bus.aluSrcMuxSel = 1'b1;
        bus.busReq       = 1'b1;
        bus.busWe        = 1'b1;
      end
      L_MEM: begin
        bus.aluSrcMuxSel = 1'b1;
        bus.busReq       = 1'b1;
      end
      L_WB: begin
        bus.aluSrcMuxSel  = 1'b1;
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = WD_MEM;
      end
      default: bus.PCEn = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mc_control_unit
//  Description : Self-checking bench for mc_control_unit. Builds the expected
//                per-cycle strobe sequence of each instruction from the
//                instruction-class rules and compares it cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

  typedef struct packed {
    logic       pcen;
    logic       we;
    logic       asel;
    logic [3:0] aluc;
    logic [2:0] wdsel;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       req;
    logic       bwe;
    logic [2:0] f3;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.pcen  = bus.PCEn;
    o.we    = bus.regFileWe;
    o.asel  = bus.aluSrcMuxSel;
    o.aluc  = bus.aluControl;
    o.wdsel = bus.RFWDSrcMuxSel;
    o.br    = bus.branch;
    o.jal   = bus.jal;
    o.jalr  = bus.jalr;
    o.req   = bus.busReq;
    o.bwe   = bus.busWe;
    o.f3    = bus.memFunct3;
    o.ill   = bus.illegalInstr;
    return o;
  endfunction

  function automatic exp_t blank(input logic [31:0] ins);
    exp_t e;
    e    = '0;
    e.f3 = ins[14:12];
    return e;
  endfunction

  // Applies one instruction from its FETCH cycle onward; `stalls` busReady-low
  // cycles are inserted in the memory phase of loads and stores.
  task automatic run_instr(input logic [31:0] ins, input int stalls, input string name);
    exp_t       q[$];
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    int         m;
    op = ins[6:0];
    f3 = ins[14:12];
    bus.instrCode = ins;

    e = blank(ins); e.pcen = 1'b1; q.push_back(e);
    e = blank(ins);
    if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67}))
      e.ill = 1'b1;
    q.push_back(e);

    e = blank(ins);
    case (op)
      7'h33: begin e.we = 1; e.aluc = {ins[30], f3}; q.push_back(e); end
      7'h13: begin
        e.we = 1; e.asel = 1;
        e.aluc = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
        q.push_back(e);
      end
      7'h63: begin e.br = 1; e.aluc = {1'b0, f3}; q.push_back(e); end
      7'h37: begin e.we = 1; e.wdsel = 3'd2; q.push_back(e); end
      7'h17: begin e.we = 1; e.wdsel = 3'd3; q.push_back(e); end
      7'h6F: begin e.jal = 1; e.we = 1; e.wdsel = 3'd4; q.push_back(e); end
      7'h67: begin e.jal = 1; e.jalr = 1; e.we = 1; e.wdsel = 3'd4; q.push_back(e); end
      7'h23: begin
        e.asel = 1; q.push_back(e);
        e.req = 1; e.bwe = 1;
        for (int k = 0; k <= stalls; k++) q.push_back(e);
      end
      7'h03: begin
        e.asel = 1; q.push_back(e);
        e.req = 1;
        for (int k = 0; k <= stalls; k++) q.push_back(e);
        e = blank(ins); e.asel = 1; e.we = 1; e.wdsel = 3'd1; q.push_back(e);
      end
      default: ;
    endcase

    m = 0;
    for (int c = 0; c < q.size(); c++) begin
      if (q[c].req) begin
        bus.busReady = (m >= stalls);
        m++;
      end else begin
        bus.busReady = 1'($urandom_range(0, 1));
      end
      #1;
      chk($sformatf("%s c%0d", name, c), 32'(observe()), 32'(q[c]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] ins;
    int          k;
    logic [6:0]  legal_ops [9];
    logic [6:0]  bad_ops   [4];
    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    bad_ops   = '{7'h73, 7'h0F, 7'h7F, 7'h00};

    reset         = 1'b1;
    bus.instrCode = 32'h0000_0000;
    bus.busReady  = 1'b0;
    #2;
    e = blank(32'h0); e.pcen = 1'b1;
    chk("reset_state", 32'(observe()), 32'(e));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed instructions
    run_instr(32'h002081B3, 0, "add");
    run_instr(32'h402081B3, 0, "sub");
    run_instr(32'h4030D293, 0, "srai");
    run_instr(32'hC0000093, 0, "addi_neg");
    run_instr(32'h0080A203, 2, "lw_stall2");
    run_instr(32'h0020A423, 0, "sw");
    run_instr(32'h00208463, 0, "beq");
    run_instr(32'h000080E7, 0, "jalr");
    run_instr(32'hFFFFFFFF, 0, "illegal");
    run_instr(32'h0000006F, 0, "jal");
    run_instr(32'h12345037, 0, "lui");
    run_instr(32'h00001097, 0, "auipc");

    // Reset asserted while a load is waiting in its memory phase
    bus.instrCode = 32'h0080A203;
    bus.busReady  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pre_req", 32'(bus.busReq), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_req", 32'(bus.busReq), 32'd0);
    chk("rst_async_pcen", 32'(bus.PCEn), 32'd1);
    bus.busReady = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = blank(32'h0080A203); e.pcen = 1'b1;
    chk("rst_fetch", 32'(observe()), 32'(e));
    run_instr(32'h002081B3, 0, "post_rst_add");

    // Randomized instruction stream with random bus stalls
    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      k   = $urandom_range(0, 10);
      if (k < 9) ins[6:0] = legal_ops[k];
      else       ins[6:0] = bad_ops[$urandom_range(0, 3)];
      run_instr(ins, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    #1;
    e = blank(bus.instrCode); e.pcen = 1'b1;
    chk("final_fetch", 32'(observe()), 32'(e));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
